// File: rtl/generic_flash_access_nios2_cpu_debug_mon_access_pkg.sv
// Shared definitions for the debug-monitor access engine: jdo field layout,
// default widths and the JTAG access FSM states.
package generic_flash_access_nios2_cpu_debug_mon_access_pkg;

    localparam int MON_ADDR_W  = 8;
    localparam int MON_DATA_W  = 32;
    localparam int JDO_W       = 38;

    localparam int JDO_ADDR_HI = 25;
    localparam int JDO_ADDR_LO = 18;
    localparam int JDO_RD_BIT  = 17;
    localparam int JDO_WD_HI   = 34;
    localparam int JDO_WD_LO   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR
    } mon_state_t;

endpackage

// File: rtl/generic_flash_access_nios2_cpu_debug_mon_ram.sv
// Single-port synchronous monitor RAM with byte enables.
// Read data registered: 1-cycle latency; q holds its value when no read is issued.
module generic_flash_access_nios2_cpu_debug_mon_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    output logic [DATA_W-1:0]     q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W/8; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/generic_flash_access_nios2_cpu_debug_mon_access.sv
// JTAG debug-monitor access engine sharing a monitor RAM with a CPU slave port.
// JTAG read 3 cycles, write 2 cycles; CPU read 1 cycle. CPU stalls while the FSM is busy or a pulse is present.
module generic_flash_access_nios2_cpu_debug_mon_access
    import generic_flash_access_nios2_cpu_debug_mon_access_pkg::*;
#(
    parameter int ADDR_W = MON_ADDR_W,
    parameter int DATA_W = MON_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [JDO_W-1:0]      jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_no_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    output logic [DATA_W-1:0]     MonDReg,
    output logic [ADDR_W-1:0]     MonAReg,
    output logic                  monitor_ready,
    output logic                  monitor_error,
    input  logic [ADDR_W-1:0]     cpu_address,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [DATA_W-1:0]     cpu_writedata,
    input  logic [DATA_W/8-1:0]   cpu_byteenable,
    output logic [DATA_W-1:0]     cpu_readdata,
    output logic                  cpu_readdatavalid,
    output logic                  cpu_waitrequest
);

    mon_state_t          state, state_nxt;
    logic [ADDR_W-1:0]   areg_nxt;
    logic [DATA_W-1:0]   dreg_nxt;
    logic                ready_nxt, error_nxt;
    logic                any_pulse, cpu_ok;

    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we, ram_re;
    logic [DATA_W/8-1:0] ram_be;
    logic [DATA_W-1:0]   ram_wdata, ram_q;

    logic                jdo_unused;
    assign jdo_unused = ^{jdo[JDO_W-1:JDO_WD_HI+1], jdo[JDO_WD_LO-1:0]};

    assign any_pulse       = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign cpu_ok          = (state == ST_IDLE) && !any_pulse;
    assign cpu_waitrequest = (cpu_read | cpu_write) & ~cpu_ok;
    assign cpu_readdata    = ram_q;

    always_comb begin
        state_nxt = state;
        areg_nxt  = MonAReg;
        dreg_nxt  = MonDReg;
        ready_nxt = monitor_ready;
        error_nxt = monitor_error;
        case (state)
            ST_IDLE: begin
                // ocimem_b outranks both address pulses; losers are dropped without error
                if (take_action_ocimem_b) begin
                    dreg_nxt  = jdo[JDO_WD_HI:JDO_WD_LO];
                    state_nxt = ST_WR;
                    ready_nxt = 1'b0;
                    error_nxt = 1'b0;
                end else if (take_action_ocimem_a) begin
                    areg_nxt  = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
                    error_nxt = 1'b0;
                    if (jdo[JDO_RD_BIT]) begin
                        state_nxt = ST_RD_ADDR;
                        ready_nxt = 1'b0;
                    end else begin
                        ready_nxt = 1'b1;
                    end
                end else if (take_no_action_ocimem_a) begin
                    areg_nxt  = MonAReg + ADDR_W'(1);
                    state_nxt = ST_RD_ADDR;
                    ready_nxt = 1'b0;
                    error_nxt = 1'b0;
                end
            end
            ST_RD_ADDR: begin
                state_nxt = ST_RD_DATA;
                if (any_pulse) error_nxt = 1'b1;
            end
            ST_RD_DATA: begin
                dreg_nxt  = ram_q;
                ready_nxt = 1'b1;
                state_nxt = ST_IDLE;
                if (any_pulse) error_nxt = 1'b1;
            end
            ST_WR: begin
                areg_nxt  = MonAReg + ADDR_W'(1);
                ready_nxt = 1'b1;
                state_nxt = ST_IDLE;
                if (any_pulse) error_nxt = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // RAM port arbitration: the JTAG FSM owns the RAM outside IDLE
    always_comb begin
        ram_addr  = MonAReg;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_be    = '1;
        ram_wdata = MonDReg;
        case (state)
            ST_WR:      ram_we = 1'b1;
            ST_RD_ADDR: ram_re = 1'b1;
            ST_IDLE: begin
                if (cpu_ok && cpu_write) begin
                    ram_addr  = cpu_address;
                    ram_we    = 1'b1;
                    ram_be    = cpu_byteenable;
                    ram_wdata = cpu_writedata;
                end else if (cpu_ok && cpu_read) begin
                    ram_addr  = cpu_address;
                    ram_re    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            MonAReg           <= '0;
            MonDReg           <= '0;
            monitor_ready     <= 1'b0;
            monitor_error     <= 1'b0;
            cpu_readdatavalid <= 1'b0;
        end else begin
            state             <= state_nxt;
            MonAReg           <= areg_nxt;
            MonDReg           <= dreg_nxt;
            monitor_ready     <= ready_nxt;
            monitor_error     <= error_nxt;
            cpu_readdatavalid <= cpu_ok && cpu_read && !cpu_write;
        end
    end

    generic_flash_access_nios2_cpu_debug_mon_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .re    (ram_re),
        .q     (ram_q)
    );

endmodule
